// File: rtl/shift_pkg.sv
// Shared encodings for the shift sequencer: op codes and controller state.
package shift_pkg;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One-position shift/rotate of a W-bit word, selected by op; pass leaves it untouched.
module shift_step
  import shift_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] data_i,
  input  logic [1:0]   op_i,
  output logic [W-1:0] data_o
);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    data_o = data_i;
    case (op_i)
      OP_SHL:  data_o = {data_i[W-2:0], 1'b0};
      OP_SHR:  data_o = {1'b0, data_i[W-1:1]};
      OP_ROL:  data_o = {data_i[W-2:0], data_i[W-1]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Round-robin front end for two requesters sharing one bit-serial shifter;
// results return on a single valid/ready channel tagged with the owner id.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_i,
  input  logic [1:0]    req0_c,
  input  logic [AW-1:0] req0_s,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_i,
  input  logic [1:0]    req1_c,
  input  logic [AW-1:0] req1_s,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_o,
  output logic          rsp_id,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [1:0]    op_q, op_d;
  logic          id_q, id_d;
  logic [AW-1:0] count_q, count_d;
  logic          ptr_q, ptr_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [W-1:0]  rsp_o_q, rsp_o_d;
  logic          rsp_id_q, rsp_id_d;
  logic          busy_q;
  logic          grant0, grant1;
  logic [W-1:0]  step_data;

  shift_step #(.W(W)) u_step (
    .data_i (data_q),
    .op_i   (op_q),
    .data_o (step_data)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    op_d        = op_q;
    id_d        = id_q;
    count_d     = count_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_o_d     = rsp_o_q;
    rsp_id_d    = rsp_id_q;
    grant0      = 1'b0;
    grant1      = 1'b0;

    case (state_q)
      IDLE: begin
        // A lone valid wins outright; a tie goes to the pointer holder.
        grant0 = req0_valid && (!req1_valid || !ptr_q);
        grant1 = req1_valid && (!req0_valid ||  ptr_q);
        if (grant0) begin
          data_d  = req0_i;
          op_d    = req0_c;
          id_d    = 1'b0;
          count_d = (req0_c == OP_PASS) ? '0 : req0_s;
          ptr_d   = 1'b1;
          state_d = SHIFT;
        end else if (grant1) begin
          data_d  = req1_i;
          op_d    = req1_c;
          id_d    = 1'b1;
          count_d = (req1_c == OP_PASS) ? '0 : req1_s;
          ptr_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (count_q == '0) begin
          state_d = DONE;
        end else begin
          data_d  = step_data;
          count_d = count_q - AW'(1);
        end
      end
      DONE: begin
        // First DONE cycle loads the response registers; afterwards they hold until taken.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_o_d     = data_q;
          rsp_id_d    = id_q;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      op_q        <= OP_PASS;
      id_q        <= 1'b0;
      count_q     <= '0;
      ptr_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_o_q     <= '0;
      rsp_id_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      op_q        <= op_d;
      id_q        <= id_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_o_q     <= rsp_o_d;
      rsp_id_q    <= rsp_id_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign req0_ready = grant0 && rst_n;
  assign req1_ready = grant1 && rst_n;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_o      = rsp_o_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = busy_q;

endmodule
